iterative_mdu: RTL and testbench
================================

# iterative_mdu

Parametrised iterative multiply/divide unit with HI/LO result registers. It serves MULT/MULTU/DIV/DIVU/MTHI/MTLO in the multi-cycle and pipelined generations of the core, and sits beside the ALU in the execute stage. Multiplication uses radix-2 shift-add and division uses restoring shift-subtract, so latency scales with WIDTH. A busy/cancel handshake lets the pipeline stall on it and flush it.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  launch the operation in op; sampled only while busy=0.
- op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  input  WIDTH  rt operand (divisor / multiplier).
- cancel  input  1  abort the in-flight operation; HI/LO left unchanged.
- busy  output  1  operation in progress; the pipeline stalls MF*/MD* while high.
- done  output  1  one-cycle pulse on the cycle after HI/LO take a mul/div result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start & op∈{0..3} latches operands and enters MUL or DIV.
  - Signed ops convert a and b to magnitudes and record the result signs.
  - start & op=4 writes hi←a; start & op=5 writes lo←a. These take one edge and never assert busy.
  - op 6/7 is ignored.
- MUL: one partial-product add and shift per cycle for WIDTH cycles into a 2·WIDTH accumulator, then FIX.
- DIV: one restoring subtract per cycle for WIDTH cycles, producing quotient and remainder, then FIX.
- FIX applies sign correction and writes HI/LO, then returns to IDLE:
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - MUL: {hi,lo} ← 2·WIDTH product.
  - DIV: lo ← quotient, hi ← remainder.
- Divide by zero (b=0) is defined, not undefined:
  - lo ← all ones, hi ← a, for both DIV and DIVU.
  - Latency is still the full DIV latency.
- Signed overflow (−2^(WIDTH−1) / −1): lo ← 2^(WIDTH−1) pattern, hi ← 0.
- start while busy=1 is ignored, including MTHI/MTLO. Holding them off is the pipeline's job.
- cancel:
  - In MUL/DIV/FIX, cancel forces IDLE on the next edge; hi/lo are not written and done does not pulse.
  - In IDLE, cancel has priority over start on the same cycle: start is dropped.
- Operands are captured at start; changes to a/b mid-operation have no effect.

## Timing
- Reset (reset=0, async): state IDLE, busy=0, done=0, hi=0, lo=0, internal accumulators 0. Outputs take these values immediately, without waiting for clk.
- Release: the first edge with reset=1 may accept start.
- Mul/div launch: start is sampled at edge E0.
  - busy=1 from E0 through edge E0+WIDTH+1, which is WIDTH iterations plus one FIX cycle.
  - hi/lo update at E0+WIDTH+1.
  - busy falls and done rises at that same edge; done lasts one cycle.
- Back-to-back: a new start is accepted at edge E0+WIDTH+1+1 at the earliest, i.e. the first edge where busy=0 is sampled.
- MTHI/MTLO: the register updates at the sampling edge and is visible the following cycle; busy stays 0.
- hi/lo are registered outputs; there is no combinational path from a/b to hi/lo.

## Test plan
- Reset and MULT, WIDTH=32:
  - Stimulus: assert reset mid-MUL; then release and issue MULT a=0xFFFFFFFD (−3), b=5.
  - Required: busy/hi/lo drop to 0 without a clock edge. After the MULT, busy high exactly 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done one cycle.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed divide:
  - DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU a=7, b=2 -> lo=3, hi=1.
- Divide corner cases:
  - DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Cancel and busy rules:
  - Preload MTHI 0xAAAA0000, MTLO 0x5555.
  - Start DIV, then pulse cancel on cycle 10 -> busy=0 next cycle; hi/lo unchanged; no done pulse.
  - MTLO issued while busy -> ignored.
- Parameter sweep, WIDTH=8:
  - MULT 0x80×0x80 -> hi=0x40, lo=0x00, busy 9 cycles.
  - Randomized mul/div with WIDTH 8 and 32 checked against a reference model, including back-to-back starts.

Source files
------------

// File: rtl/iterative_mdu.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one step per clock,
// followed by a single FIX cycle that applies signs and writes HI/LO.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here in one edge
// MUL   | one shift-add step per cycle, WIDTH steps
// DIV   | one restoring subtract per cycle, WIDTH steps
// FIX   | sign correction, HI/LO write, done pulse
module iterative_mdu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   a_raw_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic               div_zero_q;

   logic               is_signed;
   logic               launch;
   logic               mt_write;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign busy = (state_q != IDLE);

   // Operand conditioning and single-step datapath arithmetic.
   always_comb begin
      is_signed = (op == 3'd0) || (op == 3'd2);
      launch    = (state_q == IDLE) && start && !cancel && !op[2];
      mt_write  = (state_q == IDLE) && start && !cancel && (op == 3'd4 || op == 3'd5);
      a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

      // Multiply: low half of acc holds the remaining multiplier bits.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      // Divide: upper half is the partial remainder, lower half shifts
      // dividend bits out and quotient bits in.
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      div_diff  = div_shift - {1'b0, opnd_q};
      div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

      prod_fix  = neg_res_q ? -acc_q : acc_q;
      quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   // Next-state logic; cancel returns to IDLE from any active state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (launch) state_d = op[1] ? DIV : MUL;
         MUL,
         DIV: begin
            if (cancel)            state_d = IDLE;
            else if (cnt_q == '0)  state_d = FIX;
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand capture, iteration, and HI/LO write-back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q      <= '0;
         opnd_q     <= '0;
         a_raw_q    <= '0;
         cnt_q      <= '0;
         is_div_q   <= 1'b0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         done       <= 1'b0;
         hi         <= '0;
         lo         <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (launch) begin
                  acc_q      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                  opnd_q     <= op[1] ? b_mag : a_mag;
                  a_raw_q    <= a;
                  cnt_q      <= CW'(WIDTH - 1);
                  is_div_q   <= op[1];
                  neg_res_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem_q  <= is_signed && a[WIDTH-1];
                  div_zero_q <= (b == '0);
               end else if (mt_write) begin
                  if (op == 3'd4) hi <= a;
                  else            lo <= a;
               end
            end
            MUL: begin
               if (!cancel) begin
                  acc_q <= mul_next;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            DIV: begin
               if (!cancel) begin
                  acc_q <= div_next;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FIX: begin
               if (!cancel) begin
                  done <= 1'b1;
                  if (!is_div_q) begin
                     {hi, lo} <= prod_fix;
                  end else if (div_zero_q) begin
                     hi <= a_raw_q;
                     lo <= '1;
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_mdu.sv
`timescale 1ns/1ps
// Bench for iterative_mdu: WIDTH=32 and WIDTH=8 instances side by side,
// checked against an arithmetic model of the HI/LO registers.
module tb_iterative_mdu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cancel = 1'b0;
   logic        start32 = 1'b0, start8 = 1'b0;
   logic [2:0]  op32 = 3'd7, op8 = 3'd7;
   logic [31:0] a32 = '0, b32 = '0, hi32, lo32;
   logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
   logic        busy32, done32, busy8, done8;

   int checks = 0;
   int failures = 0;
   longint unsigned exp_hi [2];
   longint unsigned exp_lo [2];

   iterative_mdu #(.WIDTH(32)) u32 (
      .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
      .cancel(cancel), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32));

   iterative_mdu #(.WIDTH(8)) u8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .cancel(cancel), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8));

   always #5 clk = ~clk;

   function automatic logic [31:0] get_hi(input bit w8);
      return w8 ? {24'h0, hi8} : hi32;
   endfunction
   function automatic logic [31:0] get_lo(input bit w8);
      return w8 ? {24'h0, lo8} : lo32;
   endfunction
   function automatic logic get_busy(input bit w8);
      return w8 ? busy8 : busy32;
   endfunction
   function automatic logic get_done(input bit w8);
      return w8 ? done8 : done32;
   endfunction

   task automatic drive(input bit w8, input bit s, input logic [2:0] o,
                        input logic [31:0] av, input logic [31:0] bv);
      if (w8) begin start8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0]; end
      else    begin start32 = s; op32 = o; a32 = av; b32 = bv; end
   endtask

   // Architectural result of one operation on HI/LO.
   function automatic void model(input int w, input logic [2:0] o,
                                 input longint unsigned av, input longint unsigned bv,
                                 inout longint unsigned eh, inout longint unsigned el);
      longint unsigned mask = (64'd1 << w) - 1;
      longint          sa, sb;
      longint unsigned pu, t;
      sa = av[w-1] ? longint'(av) - longint'(64'd1 << w) : longint'(av);
      sb = bv[w-1] ? longint'(bv) - longint'(64'd1 << w) : longint'(bv);
      case (o)
         3'd0: begin pu = sa * sb; eh = (pu >> w) & mask; el = pu & mask; end
         3'd1: begin pu = av * bv; eh = (pu >> w) & mask; el = pu & mask; end
         3'd2, 3'd3: begin
            if (bv == 0) begin
               eh = av; el = mask;
            end else if (o == 3'd3) begin
               el = av / bv; eh = av % bv;
            end else if (sa == -(longint'(1) << (w - 1)) && sb == -1) begin
               el = 64'd1 << (w - 1); eh = 0;
            end else begin
               t = sa / sb; el = t & mask;
               t = sa % sb; eh = t & mask;
            end
         end
         3'd4: eh = av;
         3'd5: el = av;
         default: ;
      endcase
   endfunction

   // Issue one op at a negedge and run it to completion; returns at the
   // first negedge where busy is low, so a following call starts back-to-back.
   task automatic run_op(input bit w8, input logic [2:0] o, input logic [31:0] av,
                         input logic [31:0] bv, input string tag);
      int w = w8 ? 8 : 32;
      int n = 0;
      longint unsigned m = (64'd1 << w) - 1;
      longint unsigned avm = av & m;
      longint unsigned bvm = bv & m;
      model(w, o, avm, bvm, exp_hi[w8], exp_lo[w8]);
      drive(w8, 1'b1, o, avm[31:0], bvm[31:0]);
      @(posedge clk);
      @(negedge clk);
      drive(w8, 1'b0, 3'd7, $urandom, $urandom);
      if (o >= 3'd4) begin
         checks++;
         if (get_busy(w8) !== 1'b0) begin
            failures++; $display("FAIL %s busy: got %b expected 0", tag, get_busy(w8));
         end
      end else begin
         while (get_busy(w8) === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
         end
         checks++;
         if (n != w + 1) begin
            failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, n, w + 1);
         end
         checks++;
         if (get_done(w8) !== 1'b1) begin
            failures++; $display("FAIL %s done: got %b expected 1", tag, get_done(w8));
         end
      end
      checks++;
      if (get_hi(w8) !== exp_hi[w8][31:0]) begin
         failures++; $display("FAIL %s hi: got %h expected %h", tag, get_hi(w8), exp_hi[w8][31:0]);
      end
      checks++;
      if (get_lo(w8) !== exp_lo[w8][31:0]) begin
         failures++; $display("FAIL %s lo: got %h expected %h", tag, get_lo(w8), exp_lo[w8][31:0]);
      end
   endtask

   task automatic test_reset;
      checks++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || hi32 !== '0 || lo32 !== '0) begin
         failures++;
         $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h expected 0 0 0 0",
                  busy32, done32, hi32, lo32);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      exp_hi[0] = 0; exp_lo[0] = 0; exp_hi[1] = 0; exp_lo[1] = 0;
      run_op(0, 3'd4, 32'h1234_5678, 0, "pre_mthi");
      run_op(0, 3'd5, 32'h0000_9abc, 0, "pre_mtlo");
      drive(0, 1'b1, 3'd0, 32'h7, 32'h9);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 0, 0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (busy32 !== 1'b0 || hi32 !== '0 || lo32 !== '0) begin
         failures++;
         $display("FAIL async_reset: got busy=%b hi=%h lo=%h expected 0 0 0", busy32, hi32, lo32);
      end
      exp_hi[0] = 0; exp_lo[0] = 0; exp_hi[1] = 0; exp_lo[1] = 0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_mult;
      run_op(0, 3'd0, 32'hFFFF_FFFD, 32'd5, "mult");
      checks++;
      if (hi32 !== 32'hFFFF_FFFF || lo32 !== 32'hFFFF_FFF1) begin
         failures++; $display("FAIL mult_const: got %h_%h expected ffffffff_fffffff1", hi32, lo32);
      end
      @(negedge clk);
      checks++;
      if (done32 !== 1'b0) begin
         failures++; $display("FAIL done_width: got %b expected 0", done32);
      end
      run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
   endtask

   task automatic test_div;
      run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
      checks++;
      if (lo32 !== 32'hFFFF_FFFD || hi32 !== 32'hFFFF_FFFF) begin
         failures++; $display("FAIL div_const: got lo=%h hi=%h expected fffffffd ffffffff", lo32, hi32);
      end
      run_op(0, 3'd3, 32'd7, 32'd2, "divu");
      run_op(0, 3'd3, 32'h1234_5678, 32'd0, "divu_zero");
      run_op(0, 3'd2, 32'h1234_5678, 32'd0, "div_zero");
      run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      checks++;
      if (lo32 !== 32'h8000_0000 || hi32 !== 32'h0) begin
         failures++; $display("FAIL ovf_const: got lo=%h hi=%h expected 80000000 0", lo32, hi32);
      end
   endtask

   task automatic test_cancel;
      bit seen_done = 1'b0;
      run_op(0, 3'd4, 32'hAAAA_0000, 0, "cx_mthi");
      run_op(0, 3'd5, 32'h0000_5555, 0, "cx_mtlo");
      drive(0, 1'b1, 3'd2, 32'd1000, 32'd3);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 0, 0);
      repeat (9) @(negedge clk);
      cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cancel = 1'b0;
      checks++;
      if (busy32 !== 1'b0) begin
         failures++; $display("FAIL cancel_busy: got %b expected 0", busy32);
      end
      repeat (40) begin
         if (done32 === 1'b1) seen_done = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen_done || hi32 !== 32'hAAAA_0000 || lo32 !== 32'h0000_5555) begin
         failures++;
         $display("FAIL cancel_keep: got done_seen=%b hi=%h lo=%h expected 0 aaaa0000 00005555",
                  seen_done, hi32, lo32);
      end
      // cancel beats start in IDLE
      drive(0, 1'b1, 3'd4, 32'h1111_1111, 0);
      cancel = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cancel = 1'b0;
      drive(0, 1'b0, 3'd7, 0, 0);
      checks++;
      if (hi32 !== 32'hAAAA_0000 || busy32 !== 1'b0) begin
         failures++; $display("FAIL cancel_idle: got hi=%h busy=%b expected aaaa0000 0", hi32, busy32);
      end
   endtask

   task automatic test_busy_ignore;
      int n = 1;
      model(32, 3'd3, 100, 7, exp_hi[0], exp_lo[0]);
      drive(0, 1'b1, 3'd3, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, 3'd5, 32'h0000_DEAD, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 3'd7, 0, 0);
      while (busy32 === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 33) begin
         failures++; $display("FAIL ignore_busy_cycles: got %0d expected 33", n);
      end
      checks++;
      if (lo32 !== exp_lo[0][31:0] || hi32 !== exp_hi[0][31:0]) begin
         failures++; $display("FAIL ignore_mtlo: got lo=%h hi=%h expected %h %h",
                              lo32, hi32, exp_lo[0][31:0], exp_hi[0][31:0]);
      end
   endtask

   task automatic test_width8;
      run_op(1, 3'd0, 32'h80, 32'h80, "w8_mult");
      checks++;
      if (hi8 !== 8'h40 || lo8 !== 8'h00) begin
         failures++; $display("FAIL w8_const: got %h_%h expected 40_00", hi8, lo8);
      end
      run_op(1, 3'd2, 32'h80, 32'hFF, "w8_ovf");
      run_op(1, 3'd3, 32'h5A, 32'h00, "w8_divz");
   endtask

   task automatic test_random;
      logic [2:0]  o;
      logic [31:0] av, bv;
      int          kind;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 40; i++) begin
            o    = 3'($urandom_range(0, 5));
            kind = $urandom_range(0, 7);
            av   = $urandom;
            bv   = $urandom;
            if (kind == 0) bv = 0;
            if (kind == 1) begin
               av = (w == 1) ? 32'h80 : 32'h8000_0000;
               bv = 32'hFFFF_FFFF;
            end
            if (kind == 2) bv = $urandom_range(1, 9);
            run_op(w[0], o, av, bv, (w == 1) ? "rand8" : "rand32");
         end
      end
   endtask

   initial begin
      #1;
      test_reset;
      test_mult;
      test_div;
      test_cancel;
      test_busy_ignore;
      test_width8;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
